// File: rtl/spw_tx_crc_framer_pkg.sv
// Shared constants, state encoding and FCS byte selection for the SpaceWire
// transmit CRC framer.
package spw_tx_crc_framer_pkg;

  localparam logic [8:0]  SPW_EOP      = 9'h100;
  localparam logic [8:0]  SPW_EEP      = 9'h101;
  localparam logic [31:0] CRC32_POLY_R = 32'hEDB8_8320;

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_CRC  = 2'd1,
    S_EOP  = 2'd2
  } state_t;

  // FCS goes out least-significant byte first
  function automatic logic [7:0] fcs_byte(input logic [31:0] fcs, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = fcs[7:0];
      2'd1:    b = fcs[15:8];
      2'd2:    b = fcs[23:16];
      2'd3:    b = fcs[31:24];
      default: b = fcs[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/spw_tx_crc_framer_crc32.sv
// Combinational byte-wise step of the reflected CRC-32 (standard CRC-32 bit order).
module spw_crc32_nxt
  import spw_tx_crc_framer_pkg::*;
(
  input  logic [31:0] i_crc,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_crc
);

  logic [31:0] w_c;

  // Eight unrolled LSB-first shift/XOR steps
  always_comb begin
    w_c = i_crc ^ {24'h00_0000, i_byte};
    for (int i = 0; i < 8; i++) begin
      if (w_c[0]) begin
        w_c = {1'b0, w_c[31:1]} ^ CRC32_POLY_R;
      end else begin
        w_c = {1'b0, w_c[31:1]};
      end
    end
  end

  assign o_crc = w_c;

endmodule

// File: rtl/spw_tx_crc_framer.sv
// Transmit framer: pulls characters from the packet FIFO, forwards them to the
// SpaceWire encoder and inserts a CRC-32 in front of every EOP.
module spw_tx_crc_framer
  import spw_tx_crc_framer_pkg::*;
#(
  parameter bit          CRC_EN     = 1'b1,
  parameter logic [31:0] CRC_INIT   = 32'hFFFF_FFFF,
  parameter logic [31:0] CRC_XOROUT = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  input  logic [8:0] fifo_dout,
  output logic [8:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy,
  output logic       pkt_done
);

  state_t      r_state;
  logic [31:0] r_crc;
  logic [31:0] r_fcs;
  logic [1:0]  r_cnt;
  logic        r_rd_pend;
  logic [8:0]  r_tx_data;
  logic        r_tx_valid;
  logic        r_busy;
  logic        r_pkt_done;

  logic        w_out_free;
  logic        w_accept;
  logic        w_marker_acc;
  logic [31:0] w_crc_nxt;

  assign w_out_free   = !r_tx_valid || tx_ready;
  assign w_accept     = r_tx_valid && tx_ready;
  assign w_marker_acc = w_accept && r_tx_data[8];

  // Gated by rst_n so no character is popped (and lost) while reset is held
  assign fifo_rd = rst_n && (r_state == S_DATA) && !fifo_empty && !r_rd_pend && w_out_free;

  spw_crc32_nxt u_crc (
    .i_crc  (r_crc),
    .i_byte (fifo_dout[7:0]),
    .o_crc  (w_crc_nxt)
  );

  // Framer state machine, CRC register and registered encoder-side outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_DATA;
      r_crc      <= CRC_INIT;
      r_fcs      <= 32'h0000_0000;
      r_cnt      <= 2'd0;
      r_rd_pend  <= 1'b0;
      r_tx_data  <= 9'h000;
      r_tx_valid <= 1'b0;
      r_busy     <= 1'b0;
      r_pkt_done <= 1'b0;
    end else begin
      r_rd_pend  <= fifo_rd;
      r_pkt_done <= w_marker_acc;
      if (w_accept) begin
        r_tx_valid <= 1'b0;
      end
      if (w_marker_acc) begin
        r_busy <= 1'b0;
      end
      case (r_state)
        S_DATA: begin
          // A read is only issued when the output is free, so a returned
          // character can always be loaded straight away.
          if (r_rd_pend) begin
            if (!fifo_dout[8]) begin
              r_tx_data  <= {1'b0, fifo_dout[7:0]};
              r_tx_valid <= 1'b1;
              r_crc      <= w_crc_nxt;
              r_busy     <= 1'b1;
            end else if (fifo_dout[0]) begin
              r_tx_data  <= SPW_EEP;
              r_tx_valid <= 1'b1;
              r_crc      <= CRC_INIT;
            end else if (CRC_EN) begin
              r_fcs   <= r_crc ^ CRC_XOROUT;
              r_cnt   <= 2'd0;
              r_state <= S_CRC;
            end else begin
              r_tx_data  <= SPW_EOP;
              r_tx_valid <= 1'b1;
              r_crc      <= CRC_INIT;
            end
          end
        end
        S_CRC: begin
          if (w_out_free) begin
            r_tx_data  <= {1'b0, fcs_byte(r_fcs, r_cnt)};
            r_tx_valid <= 1'b1;
            r_cnt      <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) begin
              r_state <= S_EOP;
            end
          end
        end
        S_EOP: begin
          if (w_out_free) begin
            r_tx_data  <= SPW_EOP;
            r_tx_valid <= 1'b1;
            r_crc      <= CRC_INIT;
            r_state    <= S_DATA;
          end
        end
        default: r_state <= S_DATA;
      endcase
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign busy     = r_busy;
  assign pkt_done = r_pkt_done;

endmodule

// File: tb/tb_spw_tx_crc_framer.sv
// Randomised self-checking bench for spw_tx_crc_framer against a packet-level
// reference model (CRC computed over whole packets, expected stream per packet).
module tb_spw_tx_crc_framer;

  logic       clk;
  logic       rst_n;
  logic       fifo_empty;
  logic       fifo_rd;
  logic [8:0] fifo_dout;
  logic [8:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       pkt_done;

  logic       pt_fifo_empty;
  logic       pt_fifo_rd;
  logic [8:0] pt_fifo_dout;
  logic [8:0] pt_tx_data;
  logic       pt_tx_valid;
  logic       pt_tx_ready;
  logic       pt_busy;
  logic       pt_pkt_done;

  int n_vec = 0;
  int n_err = 0;

  logic [8:0] mem [0:4095];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic [8:0] pt_mem [0:15];
  int         pt_wr = 0;
  int         pt_rd = 0;

  logic [8:0] out_q [$];
  logic [8:0] pt_q [$];
  logic [8:0] exp_q [$];
  logic [7:0] pkt_q [$];
  int done_cnt = 0;
  int busy_cycles = 0;
  int hold_err = 0;
  int rd_err = 0;
  logic prev_stall = 1'b0;
  logic prev_rd = 1'b0;
  logic [8:0] prev_data = 9'h000;
  bit ready_rand = 1'b0;

  localparam logic [8:0] STD [14] = '{9'h031, 9'h032, 9'h033, 9'h034, 9'h035, 9'h036, 9'h037,
                                      9'h038, 9'h039, 9'h026, 9'h039, 9'h0F4, 9'h0CB, 9'h100};

  spw_tx_crc_framer u_dut (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
    .fifo_dout(fifo_dout), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .pkt_done(pkt_done)
  );

  spw_tx_crc_framer #(.CRC_EN(1'b0)) u_dut_pt (
    .clk(clk), .rst_n(rst_n), .fifo_empty(pt_fifo_empty), .fifo_rd(pt_fifo_rd),
    .fifo_dout(pt_fifo_dout), .tx_data(pt_tx_data), .tx_valid(pt_tx_valid),
    .tx_ready(pt_tx_ready), .busy(pt_busy), .pkt_done(pt_pkt_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign fifo_empty    = (wr_ptr == rd_ptr);
  assign pt_fifo_empty = (pt_wr == pt_rd);
  assign pt_tx_ready   = 1'b1;

  // Synchronous FIFO read side: data appears the cycle after the strobe
  always @(posedge clk) begin
    if (rst_n && fifo_rd) begin
      fifo_dout <= mem[rd_ptr[11:0]];
      rd_ptr    <= rd_ptr + 1;
    end
    if (rst_n && pt_fifo_rd) begin
      pt_fifo_dout <= pt_mem[pt_rd[3:0]];
      pt_rd        <= pt_rd + 1;
    end
  end

  // Encoder readiness: about 30% duty when randomised
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // Output monitor: accepted characters, pulses and protocol invariants
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) out_q.push_back(tx_data);
      if (pt_tx_valid && pt_tx_ready) pt_q.push_back(pt_tx_data);
      if (pkt_done) done_cnt <= done_cnt + 1;
      if (busy) busy_cycles <= busy_cycles + 1;
      if (prev_stall && (!tx_valid || tx_data !== prev_data)) hold_err <= hold_err + 1;
      if (prev_rd && fifo_rd) rd_err <= rd_err + 1;
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
      prev_rd    <= fifo_rd;
    end else begin
      prev_stall <= 1'b0;
      prev_rd    <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Standard CRC-32 of the whole packet held in pkt_q
  function automatic logic [31:0] ref_crc();
    logic [31:0] c = 32'hFFFF_FFFF;
    foreach (pkt_q[i]) begin
      c = c ^ {24'h00_0000, pkt_q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic model_pkt(input bit eep);
    logic [31:0] f;
    foreach (pkt_q[i]) exp_q.push_back({1'b0, pkt_q[i]});
    if (eep) begin
      exp_q.push_back(9'h101);
    end else begin
      f = ref_crc();
      for (int k = 0; k < 4; k++) exp_q.push_back({1'b0, 8'(f >> (8 * k))});
      exp_q.push_back(9'h100);
    end
  endtask

  task automatic push_pkt(input bit eep);
    foreach (pkt_q[i]) begin
      mem[wr_ptr[11:0]] = {1'b0, pkt_q[i]};
      wr_ptr++;
    end
    mem[wr_ptr[11:0]] = eep ? 9'h101 : 9'h100;
    wr_ptr++;
    pkt_q.delete();
  endtask

  task automatic load_std();
    for (int i = 0; i < 9; i++) pkt_q.push_back(8'h31 + 8'(i));
  endtask

  task automatic exp_std();
    for (int i = 0; i < 14; i++) exp_q.push_back(STD[i]);
  endtask

  task automatic wait_out(input int n, input int budget);
    int k = 0;
    while (out_q.size() < n && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (out_q.size() < n) chk("timeout", 32'(out_q.size()), 32'(n));
    repeat (6) @(negedge clk);
    #1;
  endtask

  task automatic cmp_stream(input string tag, input int base);
    chk({tag, "_len"}, 32'(out_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < out_q.size()) chk(tag, 32'(out_q[base + i]), 32'(exp_q[i]));
    end
    exp_q.delete();
  endtask

  initial begin
    int base;
    int d0;
    int b0;
    int n_mark;
    bit eep;

    // Reset with a packet already waiting: nothing may be read or driven
    rst_n = 1'b0;
    load_std();
    push_pkt(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pkt_done", 32'(pkt_done), 32'd0);
    rst_n = 1'b1;

    // Standard check string at full rate
    base = out_q.size(); d0 = done_cnt; b0 = busy_cycles;
    exp_std();
    wait_out(base + 14, 300);
    cmp_stream("std", base);
    chk("std_done", 32'(done_cnt - d0), 32'd1);
    chk("std_busy", 32'(busy_cycles > b0), 32'd1);

    // Empty packet: zero FCS, busy never raised
    base = out_q.size(); d0 = done_cnt; b0 = busy_cycles;
    push_pkt(1'b0);
    exp_q.push_back(9'h000); exp_q.push_back(9'h000);
    exp_q.push_back(9'h000); exp_q.push_back(9'h000); exp_q.push_back(9'h100);
    wait_out(base + 5, 200);
    cmp_stream("empty", base);
    chk("empty_busy", 32'(busy_cycles - b0), 32'd0);
    chk("empty_done", 32'(done_cnt - d0), 32'd1);

    // EEP packet then standard packet: CRC must restart
    base = out_q.size(); d0 = done_cnt;
    pkt_q.push_back(8'hAA); pkt_q.push_back(8'h55);
    push_pkt(1'b1);
    load_std();
    push_pkt(1'b0);
    exp_q.push_back(9'h0AA); exp_q.push_back(9'h055); exp_q.push_back(9'h101);
    exp_std();
    wait_out(base + 17, 400);
    cmp_stream("eep", base);
    chk("eep_done", 32'(done_cnt - d0), 32'd2);

    // Standard packet under backpressure
    ready_rand = 1'b1;
    base = out_q.size();
    load_std();
    push_pkt(1'b0);
    exp_std();
    wait_out(base + 14, 1000);
    cmp_stream("bp_std", base);

    // Random packets with gaps in the FIFO and random backpressure
    base = out_q.size(); d0 = done_cnt; n_mark = 0;
    for (int p = 0; p < 10; p++) begin
      int len = $urandom_range(0, 12);
      for (int i = 0; i < len; i++) pkt_q.push_back(8'($urandom));
      eep = ($urandom_range(0, 3) == 0);
      model_pkt(eep);
      push_pkt(eep);
      n_mark++;
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    wait_out(base + exp_q.size(), 4000);
    cmp_stream("rand", base);
    chk("rand_done", 32'(done_cnt - d0), 32'(n_mark));
    ready_rand = 1'b0;
    repeat (2) @(negedge clk);

    // Reset one cycle after the second CRC byte is accepted
    base = out_q.size();
    load_std();
    push_pkt(1'b0);
    begin
      int k = 0;
      while (out_q.size() < base + 11 && k < 300) begin
        @(negedge clk);
        #1;
        k++;
      end
    end
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_tx_valid", 32'(tx_valid), 32'd0);
    chk("mid_tx_data", 32'(tx_data), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_pkt_done", 32'(pkt_done), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) exp_q.push_back(STD[i]);
    repeat (4) @(negedge clk);
    #1;
    cmp_stream("abort", base);
    base = out_q.size(); d0 = done_cnt;
    load_std();
    push_pkt(1'b0);
    exp_std();
    wait_out(base + 14, 300);
    cmp_stream("after_rst", base);
    chk("after_rst_done", 32'(done_cnt - d0), 32'd1);

    // Pass-through instance: no CRC bytes inserted
    pt_mem[0] = 9'h001; pt_mem[1] = 9'h002; pt_mem[2] = 9'h100;
    pt_wr = 3;
    begin
      int k = 0;
      while (pt_q.size() < 3 && k < 100) begin
        @(negedge clk);
        #1;
        k++;
      end
    end
    repeat (6) @(negedge clk);
    chk("pt_len", 32'(pt_q.size()), 32'd3);
    if (pt_q.size() >= 3) begin
      chk("pt_0", 32'(pt_q[0]), 32'h001);
      chk("pt_1", 32'(pt_q[1]), 32'h002);
      chk("pt_2", 32'(pt_q[2]), 32'h100);
    end

    chk("hold_rule", 32'(hold_err), 32'd0);
    chk("rd_pend_rule", 32'(rd_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
